hex_segment_driver: RTL and testbench
=====================================

HEX_SEGMENT_DRIVER -- requirements
Module: hex_segment_driver

Interface
REQ-001 The block SHALL have parameter PWM_DIV, default 64, the number of clk cycles per PWM step (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state is updated on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 seg_in  input  32  segment patterns from the HEX3..HEX0 PIO out_port; byte n bits[6:0] drive digit n, and bit 7 of each byte is ignored.
REQ-005 address  input  2  Avalon-MM word address: 0 CTRL, 1 BLINK_DIV, 2 STATUS, 3 reserved.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 readdata  output  32  Avalon-MM read data, combinational from address with zero wait states.
REQ-010 hex0, hex1, hex2, hex3  output  7 each  registered, active-low segment drives.

Function
REQ-011 CTRL SHALL be read/write with these fields: bit0 enable, bits[7:4] brightness, bits[11:8] blink_mask (bit n applies to digit n); all other bits read 0.
REQ-012 BLINK_DIV SHALL be a read/write register, bits[23:0], giving the blink half-period in PWM frames; a value of 0 SHALL behave as 1.
REQ-013 STATUS SHALL be read-only with these fields: bit0 blink_phase, bits[7:4] pwm_cnt, bits[31:16] frame_cnt; writes to STATUS and to address 3 SHALL be ignored, and address 3 SHALL read 0.
REQ-014 A register write SHALL occur when chipselect=1 and write_n=0, and the new value SHALL take effect from the following cycle.
REQ-015 Prescaler SHALL count 0..PWM_DIV-1 while enabled and assert tick for one cycle at PWM_DIV-1, then wrap to 0.
REQ-016 pwm_cnt SHALL be 4 bits and advance by 1 on each tick, wrapping from 15 to 0.
REQ-017 Frame start SHALL be asserted on the cycle where tick=1 and pwm_cnt=15, and also on the first enabled cycle after enable was 0.
REQ-018 At each frame start, shadow SHALL be loaded from seg_in, and frame_cnt SHALL increment, wrapping at 16 bits.
REQ-019 seg_in changes between frame starts SHALL NOT affect the outputs; this is the anti-tearing requirement.
REQ-020 Blink counting SHALL work as follows: at each frame start, blink_cnt increments; when blink_cnt reaches max(BLINK_DIV,1)-1, it clears and blink_phase toggles.
REQ-021 A write to BLINK_DIV SHALL clear blink_cnt and blink_phase on the next cycle, and this SHALL take priority over a coincident frame start.
REQ-022 Digit n SHALL be lit when enable=1, AND (brightness=15 or pwm_cnt < brightness), AND NOT (blink_mask[n]=1 and blink_phase=1).
REQ-023 hexn SHALL register shadow byte n bits[6:0] when lit, and 7'h7F otherwise, so output latency is 1 cycle from the lit decision.
REQ-024 brightness=0 SHALL blank all digits; brightness=15 SHALL give 100% duty; brightness=k for 1..14 SHALL give k/16 duty.
REQ-025 While enable=0, prescaler, pwm_cnt, blink_cnt and blink_phase SHALL be held at 0, the outputs SHALL be 7'h7F, and shadow and frame_cnt SHALL hold their values.
REQ-026 If a CTRL write changes brightness or blink_mask in the same cycle as a frame start, the frame start SHALL use the old values, and the new values SHALL apply from the next cycle.

Reset
REQ-027 On reset_n=0, the following SHALL be applied asynchronously: CTRL = 0x000000F1 (enable=1, brightness=15, blink_mask=0); BLINK_DIV = 0x00003D; shadow = 0x40404040; prescaler, pwm_cnt, blink_cnt, blink_phase and frame_cnt = 0; hex0..hex3 = 7'h7F.
REQ-028 On release of reset_n, the first cycle SHALL count as a frame start (enable=1), and hex0..hex3 SHALL show seg_in bits[6:0] from the second cycle.
REQ-029 Reset asserted mid-frame SHALL abandon the frame, with no partial shadow update visible after release.

Verification
REQ-030 Reset release with seg_in=0x40404040 and defaults -> hex0..hex3 = 7'h40 from cycle 2 and stay constant; STATUS frame_cnt increments every 16*PWM_DIV cycles.
REQ-031 Anti-tearing: seg_in changes to 0x79247930 mid-frame -> outputs stay unchanged until the next frame start, then hex0=7'h30, hex1=7'h79, hex2=7'h24, hex3=7'h79 one cycle later.
REQ-032 Brightness: write CTRL=0x41 with PWM_DIV=4 -> each digit is lit exactly 16 of every 64 cycles; CTRL=0x01 -> outputs stay 7'h7F.
REQ-033 Blink: BLINK_DIV=2, CTRL=0x5F1 -> hex0 and hex2 blank for 2 frames and show for 2 frames alternately, hex1 and hex3 are steady, and STATUS bit0 follows blink_phase.
REQ-034 Disable/re-enable: CTRL=0x0 -> outputs are 7'h7F and STATUS pwm_cnt=0 on the next cycle; CTRL=0xF1 -> an immediate frame start, and frame_cnt increments by 1.
REQ-035 Register access: read BLINK_DIV after writing 0xFFFFFFFF -> 0x00FFFFFF; write STATUS -> no change; read address 3 -> 0.

Source files
------------

// File: rtl/hex_segment_driver_if.sv
// Avalon-MM slave bus for the 4-digit hex display driver.
interface hex_segment_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/hex_segment_driver.sv
// 4-digit 7-segment driver with PWM brightness, per-digit blink and
// frame-synchronous shadowing of the segment patterns (no tearing).
module hex_segment_driver #(
  parameter int unsigned PWM_DIV = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          seg_in,
  hex_segment_driver_if.slave  bus,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic [6:0]           hex3
);

  localparam logic [15:0] PRE_MAX = 16'(PWM_DIV - 1);

  logic        enable_q, enable_d;
  logic [3:0]  brightness_q, brightness_d;
  logic [3:0]  blink_mask_q, blink_mask_d;
  logic [23:0] blink_div_q, blink_div_d;
  logic [31:0] shadow_q, shadow_d;
  logic [15:0] prescaler_q, prescaler_d;
  logic [3:0]  pwm_cnt_q, pwm_cnt_d;
  logic [23:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        prev_en_q, prev_en_d;
  logic [3:0][6:0] hex_q, hex_d;

  logic        wr;
  logic        tick;
  logic        frame_start;
  logic [23:0] blink_last;
  logic        duty_on;
  logic        unused_bits;

  // Bits that carry no function: top writedata byte and the DP bit of each digit.
  assign unused_bits = ^{bus.writedata[31:24], seg_in[31], seg_in[23], seg_in[15], seg_in[7]};

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];

  // Zero-wait-state register read mux.
  always_comb begin
    bus.readdata = 32'h0;
    case (bus.address)
      2'd0:    bus.readdata = {20'h0, blink_mask_q, brightness_q, 3'b000, enable_q};
      2'd1:    bus.readdata = {8'h0, blink_div_q};
      2'd2:    bus.readdata = {frame_cnt_q, 8'h0, pwm_cnt_q, 3'b000, blink_phase_q};
      default: bus.readdata = 32'h0;
    endcase
  end

  // Next-state logic: register writes, prescaler/PWM, frame start, blink, outputs.
  always_comb begin
    wr           = bus.chipselect && !bus.write_n;
    enable_d     = enable_q;
    brightness_d = brightness_q;
    blink_mask_d = blink_mask_q;
    blink_div_d  = blink_div_q;
    shadow_d     = shadow_q;
    prescaler_d  = prescaler_q;
    pwm_cnt_d    = pwm_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_cnt_d  = frame_cnt_q;
    prev_en_d    = enable_q;
    hex_d        = hex_q;

    if (wr && bus.address == 2'd0) begin
      enable_d     = bus.writedata[0];
      brightness_d = bus.writedata[7:4];
      blink_mask_d = bus.writedata[11:8];
    end
    if (wr && bus.address == 2'd1) begin
      blink_div_d = bus.writedata[23:0];
    end

    // A divider of 0 behaves like 1: the blink counter never leaves 0.
    blink_last  = (blink_div_q == 24'd0) ? 24'd0 : blink_div_q - 24'd1;
    tick        = enable_q && (prescaler_q == PRE_MAX);
    // The first enabled cycle after a disabled one (including reset) starts a frame.
    frame_start = enable_q && (!prev_en_q || (tick && pwm_cnt_q == 4'd15));

    if (!enable_q) begin
      prescaler_d   = 16'd0;
      pwm_cnt_d     = 4'd0;
      blink_cnt_d   = 24'd0;
      blink_phase_d = 1'b0;
    end else begin
      prescaler_d = tick ? 16'd0 : prescaler_q + 16'd1;
      pwm_cnt_d   = tick ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
      if (frame_start) begin
        shadow_d    = seg_in;
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (blink_cnt_q == blink_last) begin
          blink_cnt_d   = 24'd0;
          blink_phase_d = !blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 24'd1;
        end
      end
    end

    // Reprogramming the blink rate restarts the blink cycle, overriding a frame start.
    if (wr && bus.address == 2'd1) begin
      blink_cnt_d   = 24'd0;
      blink_phase_d = 1'b0;
    end

    // Lit decision uses the current (old) control values; a write lands next cycle.
    duty_on = enable_q && (brightness_q == 4'd15 || pwm_cnt_q < brightness_q);
    for (int i = 0; i < 4; i++) begin
      if (duty_on && !(blink_mask_q[i] && blink_phase_q)) begin
        hex_d[i] = shadow_q[8*i +: 7];
      end else begin
        hex_d[i] = 7'h7F;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b1;
      brightness_q  <= 4'hF;
      blink_mask_q  <= 4'h0;
      blink_div_q   <= 24'h00003D;
      shadow_q      <= 32'h40404040;
      prescaler_q   <= 16'd0;
      pwm_cnt_q     <= 4'd0;
      blink_cnt_q   <= 24'd0;
      blink_phase_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
      prev_en_q     <= 1'b0;
      hex_q         <= {4{7'h7F}};
    end else begin
      enable_q      <= enable_d;
      brightness_q  <= brightness_d;
      blink_mask_q  <= blink_mask_d;
      blink_div_q   <= blink_div_d;
      shadow_q      <= shadow_d;
      prescaler_q   <= prescaler_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_cnt_q   <= frame_cnt_d;
      prev_en_q     <= prev_en_d;
      hex_q         <= hex_d;
    end
  end

endmodule

// File: tb/tb_hex_segment_driver.sv
module tb_hex_segment_driver;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] seg_in = 32'h3F065B4F;
  logic [6:0]  hex0, hex1, hex2, hex3;
  int          checks = 0;
  int          errors = 0;

  hex_segment_driver_if bus();

  hex_segment_driver #(.PWM_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .seg_in  (seg_in),
    .bus     (bus),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    $display("write addr=%0d data=%08h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic chk_hex(input string name, input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3);
    checks++;
    if ({hex3, hex2, hex1, hex0} !== {e3, e2, e1, e0}) begin
      errors++;
      $display("FAIL %s: got %h %h %h %h expected %h %h %h %h", name,
               hex3, hex2, hex1, hex0, e3, e2, e1, e0);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    step(3);
    chk_hex("reset_hex", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    rd(0, d); chk32("reset_ctrl", d, 32'h000000F1);
    rd(1, d); chk32("reset_blink_div", d, 32'h0000003D);
    rd(2, d); chk32("reset_status", d, 32'h0);
    reset_n = 1'b1;
    step(1);
    rd(2, d); chk32("first_frame_status", d, 32'h00010000);
    step(1);
    chk_hex("hex_after_release", 7'h4F, 7'h5B, 7'h06, 7'h3F);
    step(61);
    rd(2, d); chk32("status_edge63", d, 32'h000100F0);
    chk_hex("hex_steady", 7'h4F, 7'h5B, 7'h06, 7'h3F);
    step(1);
    rd(2, d); chk32("status_edge64", d, 32'h00020000);
    $display("test_reset done");
  endtask

  task automatic test_anti_tearing();
    logic [31:0] d;
    seg_in = 32'h79247930;
    step(63);
    chk_hex("tear_before_frame", 7'h4F, 7'h5B, 7'h06, 7'h3F);
    step(1);
    chk_hex("tear_at_frame", 7'h4F, 7'h5B, 7'h06, 7'h3F);
    rd(2, d); chk32("tear_frame_cnt", d, 32'h00030000);
    step(1);
    chk_hex("tear_after_frame", 7'h30, 7'h79, 7'h24, 7'h79);
    $display("test_anti_tearing done");
  endtask

  task automatic test_brightness();
    int lit [4];
    wr(0, 32'h41);
    step(2);
    lit = '{0, 0, 0, 0};
    for (int i = 0; i < 64; i++) begin
      if (hex0 != 7'h7F) lit[0]++;
      if (hex1 != 7'h7F) lit[1]++;
      if (hex2 != 7'h7F) lit[2]++;
      if (hex3 != 7'h7F) lit[3]++;
      step(1);
    end
    for (int k = 0; k < 4; k++) chk32($sformatf("bright4_lit_digit%0d", k), lit[k], 16);
    wr(0, 32'h01);
    step(2);
    lit = '{0, 0, 0, 0};
    for (int i = 0; i < 64; i++) begin
      if (hex0 != 7'h7F) lit[0]++;
      if (hex1 != 7'h7F) lit[1]++;
      if (hex2 != 7'h7F) lit[2]++;
      if (hex3 != 7'h7F) lit[3]++;
      step(1);
    end
    for (int k = 0; k < 4; k++) chk32($sformatf("bright0_lit_digit%0d", k), lit[k], 0);
    $display("test_brightness done");
  endtask

  task automatic test_blink();
    logic [31:0] s;
    logic [15:0] prev_fc;
    int          mcnt;
    logic        mph, prevph;
    int          toggles;
    wr(1, 32'd2);
    rd(2, s); chk32("blink_clear_phase", {31'h0, s[0]}, 32'h0);
    prev_fc = s[31:16]; mcnt = 0; mph = 1'b0; toggles = 0;
    wr(0, 32'h5F1);
    for (int i = 0; i <= 512; i++) begin
      if (i > 0) step(1);
      rd(2, s);
      if (s[31:16] != prev_fc) begin
        prev_fc = s[31:16];
        if (mcnt == 1) begin mcnt = 0; mph = !mph; toggles++; end
        else mcnt++;
      end
      checks++;
      if (s[0] !== mph) begin
        errors++;
        $display("FAIL blink_phase cyc%0d: got %0b expected %0b", i, s[0], mph);
      end
      if (i > 0) begin
        checks++;
        if (hex0 !== (prevph ? 7'h7F : 7'h30) || hex2 !== (prevph ? 7'h7F : 7'h24) ||
            hex1 !== 7'h79 || hex3 !== 7'h79) begin
          errors++;
          $display("FAIL blink_hex cyc%0d: got %h %h %h %h phase %0b", i, hex3, hex2, hex1, hex0, prevph);
        end
      end
      prevph = s[0];
    end
    chk32("blink_toggles", toggles, 4);
    $display("test_blink done");
  endtask

  task automatic test_disable();
    logic [31:0] d;
    logic [15:0] f;
    wr(0, 32'h0);
    step(1);
    chk_hex("disabled_hex", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    rd(2, d); chk32("disabled_pwm_phase", d & 32'h0000FFFF, 32'h0);
    f = d[31:16];
    seg_in = 32'h06060606;
    step(20);
    rd(2, d); chk32("disabled_frame_hold", d, {f, 16'h0});
    wr(0, 32'hF1);
    step(1);
    rd(2, d); chk32("reenable_frame_cnt", {16'h0, d[31:16]}, {16'h0, f + 16'd1});
    step(1);
    chk_hex("reenable_hex", 7'h06, 7'h06, 7'h06, 7'h06);
    $display("test_disable done");
  endtask

  task automatic test_registers();
    logic [31:0] d;
    wr(1, 32'hFFFFFFFF);
    rd(1, d); chk32("blink_div_mask", d, 32'h00FFFFFF);
    wr(0, 32'hFFFFFFFF);
    rd(0, d); chk32("ctrl_mask", d, 32'h00000FF1);
    wr(0, 32'h000000F1);
    wr(2, 32'hFFFFFFFF);
    rd(2, d); chk32("status_unused_zero", d & 32'h0000FF0E, 32'h0);
    rd(0, d); chk32("ctrl_after_status_wr", d, 32'h000000F1);
    rd(1, d); chk32("div_after_status_wr", d, 32'h00FFFFFF);
    wr(3, 32'hFFFFFFFF);
    rd(3, d); chk32("addr3_reads_zero", d, 32'h0);
    rd(0, d); chk32("ctrl_after_addr3_wr", d, 32'h000000F1);
    $display("test_registers done");
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    wr(0, 32'h3F1);
    step(10);
    reset_n = 1'b0;
    #1;
    chk_hex("async_reset_hex", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    rd(0, d); chk32("mid_reset_ctrl", d, 32'h000000F1);
    rd(2, d); chk32("mid_reset_status", d, 32'h0);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk_hex("mid_reset_shadow", 7'h40, 7'h40, 7'h40, 7'h40);
    step(1);
    chk_hex("mid_reset_reload", 7'h06, 7'h06, 7'h06, 7'h06);
    $display("test_mid_reset done");
  endtask

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    test_reset();
    test_anti_tearing();
    test_brightness();
    test_blink();
    test_disable();
    test_registers();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
